// File: rtl/nx_fifo_wr_arb.sv
// rtl/nx_fifo_wr_arb.sv - round-robin write arbiter in front of an nx_fifo write port
//
// Shares one FIFO write port among NUM_REQ producers. At most one valid/ready
// transfer per cycle, gated on the FIFO free-slot count so the FIFO cannot
// overflow, and a DRAIN/CLEAR/DONE sequence that clears the FIFO on flush_req.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid         per-requester write request
//   req_data          requester i data at [i*DATA_W +: DATA_W]
//   req_ready         one-hot or zero, combinational grant
//   fifo_free_slots   FIFO free-slot count
//   fifo_overflow     FIFO overflow pulse
//   fifo_wen          registered FIFO write enable
//   fifo_wdata        registered FIFO write data
//   fifo_clear        registered one-cycle FIFO clear
//   flush_req         request to discard FIFO contents
//   flush_done        one-cycle pulse at flush completion
//   grant_id          index of the last granted requester
//   busy              high while a flush is in progress
//   err_ovf           sticky FIFO overflow flag, cleared at flush completion
//   grant_cnt         per-requester 16-bit grant counters
//
// Optional feature: define NX_FIFO_WR_ARB_STATS_EN to build the grant
// counters; otherwise grant_cnt is tied to zero.

module nx_fifo_wr_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SLOT_W  = 3,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [SLOT_W-1:0]         fifo_free_slots,
    input  logic                      fifo_overflow,
    output logic                      fifo_wen,
    output logic [DATA_W-1:0]         fifo_wdata,
    output logic                      fifo_clear,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      err_ovf,
    output logic [NUM_REQ*16-1:0]     grant_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic              grant;
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First valid requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        int t;
        win_found = 1'b0;
        win_id    = '0;
        t         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            t = int'(rr_ptr) + k;
            if (t >= NUM_REQ) begin
                t = t - NUM_REQ;
            end
            if (!win_found && req_valid[ID_W'(t)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(t);
            end
        end
    end

    // free_slots lags our own registered write by a cycle, so an outstanding
    // fifo_wen consumes one of the reported slots. A flush request wins over
    // any grant in the same cycle.
    assign grant = (state == S_RUN) && !flush_req && win_found &&
                   (fifo_free_slots > {{(SLOT_W-1){1'b0}}, fifo_wen});

    assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (flush_req) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            rr_ptr     <= '0;
            fifo_wen   <= 1'b0;
            fifo_wdata <= '0;
            grant_id   <= '0;
            fifo_clear <= 1'b0;
            flush_done <= 1'b0;
            busy       <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state      <= state_nxt;
            fifo_wen   <= grant;
            // Flag outputs are registered from the next state so they line
            // up exactly with the state they describe.
            fifo_clear <= (state_nxt == S_CLEAR);
            flush_done <= (state_nxt == S_DONE);
            busy       <= (state_nxt != S_RUN);
            if (grant) begin
                fifo_wdata <= data_arr[win_id];
                grant_id   <= win_id;
                rr_ptr     <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
            end
            // Set has priority over the DONE clear.
            if (fifo_overflow) begin
                err_ovf <= 1'b1;
            end else if (state == S_DONE) begin
                err_ovf <= 1'b0;
            end
        end
    end

`ifdef NX_FIFO_WR_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // No grant can coincide with DONE, so the clear and increment never race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (state == S_DONE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (grant) begin
            cnt_q[win_id] <= cnt_q[win_id] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt_q[g];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule
